// File: rtl/atm_keypad_initiator.sv
// atm_keypad_initiator: collects keypad entries, issues one ATM request and reports its outcome.
module atm_keypad_initiator #(
  parameter int TIMEOUT_CYC = 64,
  parameter int AMT_DIGITS = 6,
  parameter logic [3:0] NO_ACC = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        lang_sel,
  input  logic [2:0]  atm_state,
  input  logic        atm_success,
  input  logic [31:0] atm_balance,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] new_pin,
  output logic [31:0] amount,
  output logic [2:0]  operation,
  output logic        language,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [31:0] bal_out
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {S_ACC, S_PIN, S_OP, S_AMT, S_NPIN, S_ISSUE, S_BUSY, S_DONE} state_t;
  state_t r_state;
  logic [3:0] r_acc;
  logic r_acc_ok;
  logic [7:0] r_cnt;
  logic [2:0] r_op;
  logic [TW-1:0] r_tmo;
  logic r_seen;
  logic w_dig, w_ent, w_clr, w_col, w_wipe, w_go, w_fin, w_op_st, w_tmo;
  logic [1:0] w_res;
  logic [2:0] w_go_op;
  logic [31:0] w_amt;
  assign w_dig = key_valid && key <= 4'd9;
  assign w_ent = key_valid && key == 4'hA;
  assign w_clr = key_valid && key == 4'hB;
  assign w_col = r_state inside {S_ACC, S_PIN, S_OP, S_AMT, S_NPIN};
  // cancel, menu exit and the single DONE cycle all funnel into the same wipe
  assign w_wipe = (w_col && key_valid && key == 4'hC) || (r_state == S_OP && w_dig && key == 4'd5) || r_state == S_DONE;
  assign w_go = (r_state == S_OP && w_dig && key == 4'd1) || (r_state == S_AMT && w_ent && r_cnt != 8'd0) ||
                (r_state == S_NPIN && w_ent && r_cnt == 8'd4);
  assign w_go_op = r_state == S_OP ? 3'd3 : r_op;
  assign w_op_st = atm_state >= 3'd3 && atm_state <= 3'd6;
  assign w_tmo = r_tmo == TW'(TIMEOUT_CYC - 1);
  // a WAITING return seen in BUSY wins over an expiring timeout
  assign w_fin = (r_state == S_ISSUE && w_tmo) || (r_state == S_BUSY && (atm_state == 3'd0 || w_tmo));
  assign w_res = (r_state == S_BUSY && atm_state == 3'd0) ? (r_seen ? {1'b0, !atm_success} : 2'd2) : 2'd3;
  assign w_amt = (amount << 3) + (amount << 1) + {28'd0, key};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ACC;
      r_acc <= '0;
      r_acc_ok <= 1'b0;
      r_cnt <= '0;
      r_op <= '0;
      r_tmo <= '0;
      r_seen <= 1'b0;
      acc_num <= NO_ACC;
      pin <= '0;
      new_pin <= '0;
      amount <= '0;
      operation <= '0;
      language <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      bal_out <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_ACC:
          if (w_dig) begin
            if (!r_acc_ok) language <= lang_sel;
            r_acc <= key;
            r_acc_ok <= 1'b1;
          end else if (w_clr) begin
            r_acc <= '0;
            r_acc_ok <= 1'b0;
          end else if (w_ent && r_acc_ok) r_state <= S_PIN;
        S_PIN:
          if (w_dig && r_cnt < 8'd4) begin
            pin <= {pin[11:0], key};
            r_cnt <= r_cnt + 8'd1;
          end else if (w_clr) begin
            pin <= '0;
            r_cnt <= '0;
          end else if (w_ent && r_cnt == 8'd4) begin
            r_cnt <= '0;
            r_state <= S_OP;
          end
        S_OP:
          if (w_dig && key inside {[4'd2:4'd4]}) begin
            r_op <= 3'(key + 4'd2);
            r_state <= key == 4'd4 ? S_NPIN : S_AMT;
          end
        S_AMT:
          if (w_dig && r_cnt < 8'(AMT_DIGITS)) begin
            amount <= w_amt;
            r_cnt <= r_cnt + 8'd1;
          end else if (w_clr) begin
            amount <= '0;
            r_cnt <= '0;
          end
        S_NPIN:
          if (w_dig && r_cnt < 8'd4) begin
            new_pin <= {new_pin[11:0], key};
            r_cnt <= r_cnt + 8'd1;
          end else if (w_clr) begin
            new_pin <= '0;
            r_cnt <= '0;
          end
        S_ISSUE: begin
          r_seen <= w_op_st;
          r_tmo <= r_tmo + TW'(1);
          if (atm_state != 3'd0) r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_seen <= r_seen || w_op_st;
          r_tmo <= r_tmo + TW'(1);
        end
        default: ;
      endcase
      if (w_go) begin
        r_state <= S_ISSUE;
        acc_num <= r_acc;
        operation <= w_go_op;
        busy <= 1'b1;
        r_tmo <= '0;
        r_seen <= 1'b0;
      end
      if (w_fin) begin
        r_state <= S_DONE;
        done <= 1'b1;
        result <= w_res;
        bal_out <= atm_balance;
      end
      if (w_wipe) begin
        r_state <= S_ACC;
        r_acc <= '0;
        r_acc_ok <= 1'b0;
        r_cnt <= '0;
        r_op <= '0;
        acc_num <= NO_ACC;
        pin <= '0;
        new_pin <= '0;
        amount <= '0;
        operation <= '0;
        language <= 1'b0;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_atm_keypad_initiator.sv
// tb_atm_keypad_initiator: vector table, directed corner sequences and random transactions against a simple ATM model.
module tb_atm_keypad_initiator;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] key = '0;
  logic key_valid = 1'b0, lang_sel = 1'b0;
  logic [2:0] atm_state;
  logic atm_success;
  logic [31:0] atm_balance;
  logic [3:0] acc_num;
  logic [15:0] pin, new_pin;
  logic [31:0] amount, bal_out;
  logic [2:0] operation;
  logic language, busy, done;
  logic [1:0] result;
  int n_chk = 0, n_fail = 0;
  bit atm_stuck = 0, atm_succ = 1, served = 0, noise = 0;

  typedef struct {logic [3:0] k; logic [55:0] e;} vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  atm_keypad_initiator dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .lang_sel(lang_sel),
    .atm_state(atm_state), .atm_success(atm_success), .atm_balance(atm_balance),
    .acc_num(acc_num), .pin(pin), .new_pin(new_pin), .amount(amount), .operation(operation),
    .language(language), .busy(busy), .done(done), .result(result), .bal_out(bal_out)
  );

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ATM: every account has PIN 1234 and balance 1000*(acc+1)
  task automatic atm_seq();
    atm_balance = (32'(acc_num) + 32'd1) * 32'd1000;
    atm_success = 1'b0;
    atm_state = 3'd1;
    step(2);
    if (atm_stuck) begin
      atm_state = 3'd2;
      for (int i = 0; i < 300 && operation != 3'd0; i++) step(1);
      atm_state = 3'd0;
    end else if (pin == 16'h1234) begin
      atm_state = 3'd2;
      step(1);
      atm_state = operation;
      step(2);
      atm_success = atm_succ;
      atm_state = 3'd0;
    end else atm_state = 3'd0;
  endtask

  initial begin
    atm_state = 3'd0;
    atm_success = 1'b0;
    atm_balance = '0;
    forever begin
      @(posedge clk); #1;
      if (operation == 3'd0) begin served = 0; atm_state = 3'd0; end
      else if (!served) begin served = 1; atm_seq(); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    if (noise && $urandom_range(0, 3) == 0) begin
      key = 4'(4'hD + 4'($urandom_range(0, 2)));
      key_valid = 1'b1;
      @(negedge clk);
    end
    key = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [3:0] acc, input logic lang, input logic [15:0] pv, input int opd,
                        input int nd, input logic [31:0] ds, input logic [15:0] np);
    lang_sel = lang;
    press(acc);
    press(4'hA);
    for (int i = 0; i < 4; i++) press(pv[15-4*i -: 4]);
    press(4'hA);
    press(4'(opd));
    if (opd == 2 || opd == 3) begin
      for (int i = 0; i < nd; i++) press(ds[31-4*i -: 4]);
      press(4'hA);
    end else if (opd == 4) begin
      for (int i = 0; i < 4; i++) press(np[15-4*i -: 4]);
      press(4'hA);
    end
  endtask

  task automatic expect_issue(input string nm, input logic [3:0] a, input logic [2:0] o, input logic l,
                              input logic [15:0] p, input logic [15:0] q, input logic [31:0] m);
    chk(nm, 128'({acc_num, operation, busy, language, pin, new_pin, amount}), 128'({a, o, 1'b1, l, p, q, m}));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, 128'({acc_num, operation, busy, done, language, pin, new_pin, amount}),
        128'({4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0}));
  endtask

  task automatic finish_chk(input string nm, input logic [1:0] res, input logic [31:0] bal);
    int n;
    wait_done(n);
    if (!done) chk({nm, "_done"}, 128'(done), 128'(1));
    else begin
      chk({nm, "_res"}, 128'({result, bal_out}), 128'({res, bal}));
      @(negedge clk);
      chk_idle({nm, "_idle"});
    end
  endtask

  function automatic vec_t mk(input logic [3:0] k, input logic [3:0] a, input logic [2:0] o, input logic b,
                              input logic [15:0] p, input logic [31:0] m);
    vec_t v;
    v.k = k;
    v.e = {a, o, b, p, m};
    return v;
  endfunction

  function automatic logic [31:0] rnd_bcd();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    logic [31:0] am, ds, r;
    logic [15:0] pv, np;
    logic [3:0] acc;
    logic lang;
    int opd, nd, n, d;
    longint ea;
    logic [1:0] er;
    am = '0;
    foreach (tbl[i]) tbl.delete(i);
    tbl.push_back(mk(4'hA, 4'hF, 3'd0, 1'b0, 16'h0000, 32'd0));
    tbl.push_back(mk(4'h7, 4'hF, 3'd0, 1'b0, 16'h0000, 32'd0));
    tbl.push_back(mk(4'hB, 4'hF, 3'd0, 1'b0, 16'h0000, 32'd0));
    tbl.push_back(mk(4'h1, 4'hF, 3'd0, 1'b0, 16'h0000, 32'd0));
    tbl.push_back(mk(4'hA, 4'hF, 3'd0, 1'b0, 16'h0000, 32'd0));
    tbl.push_back(mk(4'h1, 4'hF, 3'd0, 1'b0, 16'h0001, 32'd0));
    tbl.push_back(mk(4'hE, 4'hF, 3'd0, 1'b0, 16'h0001, 32'd0));
    tbl.push_back(mk(4'h2, 4'hF, 3'd0, 1'b0, 16'h0012, 32'd0));
    tbl.push_back(mk(4'h3, 4'hF, 3'd0, 1'b0, 16'h0123, 32'd0));
    tbl.push_back(mk(4'hA, 4'hF, 3'd0, 1'b0, 16'h0123, 32'd0));
    tbl.push_back(mk(4'hB, 4'hF, 3'd0, 1'b0, 16'h0000, 32'd0));
    tbl.push_back(mk(4'h1, 4'hF, 3'd0, 1'b0, 16'h0001, 32'd0));
    tbl.push_back(mk(4'h2, 4'hF, 3'd0, 1'b0, 16'h0012, 32'd0));
    tbl.push_back(mk(4'h3, 4'hF, 3'd0, 1'b0, 16'h0123, 32'd0));
    tbl.push_back(mk(4'h4, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'h5, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'hA, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'h9, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'hB, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'h2, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    for (int i = 0; i < 7; i++) begin
      if (i < 6) am = am * 32'd10 + 32'd1;
      tbl.push_back(mk(4'h1, 4'hF, 3'd0, 1'b0, 16'h1234, am));
    end
    tbl.push_back(mk(4'hB, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'h7, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd7));
    tbl.push_back(mk(4'hB, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd0));
    tbl.push_back(mk(4'h4, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd4));
    tbl.push_back(mk(4'h2, 4'hF, 3'd0, 1'b0, 16'h1234, 32'd42));
    tbl.push_back(mk(4'hA, 4'h1, 3'd4, 1'b1, 16'h1234, 32'd42));

    #23;
    chk("reset", 128'({acc_num, pin, new_pin, amount, operation, language, busy, done, result, bal_out}),
        128'({4'hF, 16'd0, 16'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0}));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].k);
      chk($sformatf("tbl%0d", i), 128'({acc_num, operation, busy, pin, amount}), 128'(tbl[i].e));
    end
    finish_chk("tbl", 2'd0, 32'd2000);

    do_txn(4'd3, 1'b1, 16'h1234, 1, 0, 32'd0, 16'd0);
    expect_issue("bal_issue", 4'd3, 3'd3, 1'b1, 16'h1234, 16'd0, 32'd0);
    finish_chk("bal", 2'd0, 32'd4000);

    do_txn(4'd1, 1'b0, 16'h1234, 2, 3, 32'h50000000, 16'd0);
    expect_issue("wd500_issue", 4'd1, 3'd4, 1'b0, 16'h1234, 16'd0, 32'd500);
    finish_chk("wd500", 2'd0, 32'd2000);

    atm_succ = 0;
    do_txn(4'd1, 1'b0, 16'h1234, 2, 5, 32'h99999000, 16'd0);
    expect_issue("wd99999_issue", 4'd1, 3'd4, 1'b0, 16'h1234, 16'd0, 32'd99999);
    finish_chk("wd99999", 2'd1, 32'd2000);
    atm_succ = 1;

    do_txn(4'd2, 1'b0, 16'h1111, 1, 0, 32'd0, 16'd0);
    finish_chk("badpin", 2'd2, 32'd3000);

    do_txn(4'd4, 1'b0, 16'h1234, 4, 0, 32'd0, 16'h5678);
    expect_issue("npin_issue", 4'd4, 3'd6, 1'b0, 16'h1234, 16'h5678, 32'd0);
    finish_chk("npin", 2'd0, 32'd5000);

    do_txn(4'd0, 1'b1, 16'h1234, 3, 8, 32'h12345678, 16'd0);
    expect_issue("dep_issue", 4'd0, 3'd5, 1'b1, 16'h1234, 16'd0, 32'd123456);
    finish_chk("dep", 2'd0, 32'd1000);

    lang_sel = 1'b1;
    press(4'h1); press(4'hA);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    press(4'h3); press(4'h9); press(4'hC);
    chk_idle("cancel_amt");
    d = 0;
    repeat (5) begin @(negedge clk); d += int'(done); end
    chk("cancel_nodone", 128'(d), 128'(0));

    press(4'h2); press(4'hA);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    press(4'h5);
    chk_idle("exit_op");
    press(4'hA);
    chk_idle("enter_empty_acc");

    do_txn(4'd6, 1'b0, 16'h1234, 2, 3, 32'h50000000, 16'd0);
    press(4'hC); press(4'h9); press(4'hA);
    chk("busy_keys", 128'({acc_num, operation, amount, busy}), 128'({4'd6, 3'd4, 32'd500, 1'b1}));
    finish_chk("busy_keys", 2'd0, 32'd7000);

    noise = 1;
    for (int t = 0; t < 24; t++) begin
      acc = 4'($urandom_range(0, 9));
      lang = 1'($urandom_range(0, 1));
      opd = int'($urandom_range(1, 4));
      r = rnd_bcd();
      pv = $urandom_range(0, 3) == 0 ? r[15:0] : 16'h1234;
      nd = int'($urandom_range(1, 8));
      ds = rnd_bcd();
      np = r[31:16];
      atm_succ = 1'($urandom_range(0, 1));
      ea = 0;
      if (opd == 2 || opd == 3)
        for (int i = 0; i < nd && i < 6; i++) ea = ea * 10 + longint'(ds[31-4*i -: 4]);
      er = pv != 16'h1234 ? 2'd2 : (atm_succ ? 2'd0 : 2'd1);
      do_txn(acc, lang, pv, opd, nd, ds, np);
      expect_issue($sformatf("rnd%0d_issue", t), acc, 3'(opd + 2), lang, pv, opd == 4 ? np : 16'd0, 32'(ea));
      finish_chk($sformatf("rnd%0d", t), er, (32'(acc) + 32'd1) * 32'd1000);
    end
    noise = 0;
    atm_succ = 1;

    atm_stuck = 1;
    do_txn(4'd5, 1'b0, 16'h1234, 1, 0, 32'd0, 16'd0);
    wait_done(n);
    chk("tmo_cycles", 128'(n), 128'(64));
    chk("tmo_res", 128'({done, result, bal_out}), 128'({1'b1, 2'd3, 32'd6000}));
    @(negedge clk);
    chk_idle("tmo_idle");

    do_txn(4'd7, 1'b1, 16'h1234, 2, 2, 32'h12000000, 16'd0);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 128'({busy, acc_num}), 128'({1'b1, 4'd7}));
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 128'({acc_num, pin, new_pin, amount, operation, language, busy, done, result, bal_out}),
        128'({4'hF, 16'd0, 16'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0}));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    atm_stuck = 0;
    repeat (2) @(negedge clk);

    do_txn(4'd8, 1'b0, 16'h1234, 1, 0, 32'd0, 16'd0);
    expect_issue("post_rst_issue", 4'd8, 3'd3, 1'b0, 16'h1234, 16'd0, 32'd0);
    finish_chk("post_rst", 2'd0, 32'd9000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/atm_keypad_initiator.md
Name: atm_keypad_initiator

Overview:
- Customer-side front end that drives the ATM controller's request interface.
- Collects serial keypad codes (account, PIN, operation, amount or new PIN) and assembles the ATM's parallel inputs.
- Issues the request and tracks the ATM's state output until the transaction finishes.
- Reports a one-cycle done pulse with a result code and the captured balance.

Parameters:
- TIMEOUT_CYC, 64: maximum cycles in ISSUE+BUSY before aborting with TIMEOUT.
- AMT_DIGITS, 6: maximum amount digits; further digits are ignored.
- NO_ACC, 4'hF: acc_num value driven while idle; never matches a stored account.

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- key  in  4  keypad code: 0-9 digit, A ENTER, B CLEAR, C CANCEL, D-F ignored
- key_valid  in  1  one-cycle strobe qualifying key
- lang_sel  in  1  language request, latched on first account digit
- atm_state  in  3  ATM state: 0 WAITING, 1 AUTH, 2 MENU, 3 BALANCE, 4 WITHDRAW, 5 DEPOSIT, 6 CHANGE_PIN
- atm_success  in  1  ATM success flag
- atm_balance  in  32  ATM balance output
- acc_num  out  4  account to ATM
- pin  out  16  BCD PIN, first digit in [15:12]
- new_pin  out  16  BCD new PIN, same packing as pin
- amount  out  32  binary amount
- operation  out  3  operation code (3/4/5/6 as atm_state); 0 when idle
- language  out  1  latched lang_sel
- busy  out  1  high in ISSUE, BUSY, DONE
- done  out  1  one-cycle completion pulse
- result  out  2  0 OK, 1 OP_FAIL, 2 AUTH_FAIL, 3 TIMEOUT; valid with done, held until next done
- bal_out  out  32  atm_balance captured at done

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. Low rst at any time, including mid-transaction, forces:
  - state to ACC; acc_num = NO_ACC
  - pin, new_pin, amount, operation, language = 0
  - busy, done = 0; result = 0; bal_out = 0; timeout counter cleared
- Keys are processed only in the collection states (ACC, PIN, OP, AMT, NPIN), one per key_valid cycle.
- Keys arriving during ISSUE, BUSY or DONE are dropped.
- CANCEL in any collection state clears all fields and returns to ACC, with no done pulse.
- CLEAR empties the current field only.
- ACC state:
  - A digit stores the account into an internal register; acc_num stays NO_ACC.
  - ENTER with the field filled goes to PIN; ENTER with the field empty is ignored.
- PIN state:
  - Digits shift in nibble-wise; digits beyond 4 are ignored.
  - ENTER goes to OP only with exactly 4 digits.
- OP state (digit acts immediately, no ENTER):
  - 1 selects BALANCE (3) and goes to ISSUE.
  - 2 selects WITHDRAW (4) and 3 selects DEPOSIT (5); both go to AMT.
  - 4 selects CHANGE_PIN (6) and goes to NPIN.
  - 5 (exit) acts as CANCEL.
  - Other digits are ignored.
- AMT state:
  - Each digit updates amount = amount*10 + d, with 32-bit arithmetic (x*8 + x*2).
  - Digits beyond AMT_DIGITS are ignored.
  - ENTER with at least 1 digit goes to ISSUE.
- NPIN state: same rules as PIN, then goes to ISSUE.
- ISSUE state:
  - Registered outputs drive the real acc_num, the chosen operation and language; busy = 1; timeout counter starts at 0.
  - Outputs stay stable until DONE.
  - When atm_state != 0, go to BUSY.
- BUSY state:
  - Sets seen_op when atm_state is in 3..6.
  - When atm_state returns to 0:
    - with seen_op: result = atm_success ? OK : OP_FAIL.
    - without seen_op: result = AUTH_FAIL (AUTH went straight back to WAITING).
  - Then go to DONE.
- Timeout: the counter increments every ISSUE/BUSY cycle. Reaching TIMEOUT_CYC-1 forces result = TIMEOUT and goes to DONE.
- DONE state (one cycle):
  - done = 1; bal_out = atm_balance; result updated.
  - Next cycle: acc_num = NO_ACC, operation = 0, fields cleared, busy = 0, state ACC.
- Simultaneous events: the timeout expiring on the same cycle as WAITING return is reported as the normal result, not TIMEOUT.

Test Plan:
- Balance: keys 3,A,1,2,3,4,A,1 with ATM model acc3/PIN 1234 -> pin = 16'h1234; ISSUE drives acc_num = 3, operation = 3; done with result 0, bal_out = 4000.
- Withdraw: keys 1,A,PIN,A,2,5,0,0,A -> amount = 500, operation = 4; ATM success = 1 -> result 0; repeat with amount 99999 and success = 0 -> result 1.
- Wrong PIN: ATM goes 1 -> 0 without an op state -> done with result 2, bal_out captured, acc_num back to 4'hF next cycle.
- Editing: in AMT, keys 7,B,4,2,A -> amount = 42; 7 digits 1111111 -> amount = 111111; in PIN, ENTER after 3 digits -> stays in PIN.
- Cancel/exit: C during AMT, and digit 5 in OP -> return to ACC, no done, fields zero; keys sent during BUSY have no effect.
- Timeout/reset: atm_state stuck at 2 -> done at cycle TIMEOUT_CYC with result 3; rst low mid-BUSY -> all outputs at reset values immediately.
